memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Shares the single RAM port between the datapath's instruction-fetch and data-memory requests.
//  Sits between the datapath/cache request lines and RAM, and sequences one access at a time.
//  Data requests have priority (the pipeline stalls on them); a starvation counter bounds fetch latency.
//  Generates the ihit/dhit-style completion strobes the pipeline registers qualify on.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data word width
//  STARVE_MAX  4   consecutive data grants allowed while a fetch waits; 1..15
// PORTS
//  CLK       in   1       clock, rising edge
//  RST       in   1       reset, asynchronous, active-high
//  iREN      in   1       instruction fetch request (level, held until ihit)
//  iaddr     in   ADDR_W  fetch address
//  ihit      out  1       fetch complete this cycle; iload valid
//  iload     out  DATA_W  fetched word
//  dREN      in   1       data read request (level, held until dhit)
//  dWEN      in   1       data write request (level, held until dhit)
//  daddr     in   ADDR_W  data address
//  dstore    in   DATA_W  write data
//  dhit      out  1       data access complete this cycle; dload valid on reads
//  dload     out  DATA_W  read data
//  ramREN    out  1       RAM read strobe
//  ramWEN    out  1       RAM write strobe
//  ramaddr   out  ADDR_W  RAM address
//  ramstore  out  DATA_W  RAM write data
//  ramload   in   DATA_W  RAM read data
//  ramready  in   1       RAM access done this cycle (any latency >=1 cycle)
// BEHAVIOUR
//  Reset: state=IDLE, starve=0, latched regs=0; ihit/dhit/ramREN/ramWEN=0, ramaddr/ramstore=0 immediately.
//  FSM states: IDLE, DSERV, ISERV.
//  IDLE: if (dREN|dWEN) && !(iREN && starve==STARVE_MAX) -> DSERV; else if iREN -> ISERV; else stay.
//  On a grant, latch addr, op (write if dWEN), store data; RAM is driven only from the latched regs.
//  DSERV/ISERV: hold ramREN/ramWEN/ramaddr/ramstore constant until ramready; on ramready -> IDLE.
//  Completion: dhit = DSERV & ramready & (dREN|dWEN); ihit = ISERV & ramready & iREN (combinational).
//  dload/iload = ramload passthrough; value don't-care when the matching hit=0.
//  Latency: request seen in IDLE -> grant next edge -> hit in the cycle ramready rises; min 2 cycles.
//  One IDLE bubble between consecutive accesses; no back-to-back grants.
//  dREN&dWEN both high: illegal; the access is a write (ramWEN=1, ramREN=0).
//  Requester drops its request mid-service: RAM access still completes; its hit is suppressed.
//  Starvation: starve++ (saturating at STARVE_MAX) on each data grant while iREN=1; cleared on an ISERV grant.
//  With starve==STARVE_MAX and iREN=1, the fetch wins the next IDLE decision even if data is pending.
//  RST asserted mid-access: abort at once; RAM strobes drop asynchronously; no hit issued.
// CONFIGURATION
//  MEMARB_PERF_EN defined: adds out ports istall_cnt[31:0] and dstall_cnt[31:0]; each counts cycles
//    its request is high without a hit, saturates at 32'hFFFF_FFFF, and resets to 0.
//  Not defined: the ports and counters do not exist; behaviour is otherwise identical.
// TESTING
//  iREN=1 alone, iaddr=0x40, RAM latency 3 -> ramREN=1 with ramaddr=0x40 for 3 cycles; ihit=1 exactly once.
//  iREN+dREN raised together -> DSERV first; ihit follows after one IDLE bubble; dhit precedes ihit.
//  STARVE_MAX=4, iREN held, dREN continuous -> 4 dhits, then ihit, then data resumes.
//  dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1 with those values held until ramready; dhit=1.
//  dREN dropped mid DSERV -> ramREN stays until ramready; dhit=0; FSM returns to IDLE.
//  RST pulsed during ISERV -> ramREN=0 the same cycle; state IDLE; starve=0; no ihit.

Source files
------------

// File: rtl/memory_arbiter.sv
// Serialises instruction-fetch and data requests onto one RAM port; data wins unless a waiting
// fetch has been passed over STARVE_MAX times. Define MEMARB_PERF_EN for stall-cycle counters.
module memory_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready
`ifdef MEMARB_PERF_EN
    ,
    output logic [31:0]       istall_cnt,
    output logic [31:0]       dstall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    function automatic logic [3:0] starve_inc(input logic [3:0] v);
        return (v >= STARVE_LIM) ? STARVE_LIM : v + 4'd1;
    endfunction

    state_t            state, state_nx;
    logic [3:0]        starve;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] store_p0;
    logic              ren_p0, wen_p0;
    logic              d_req, fetch_due, grant_d, grant_i;

    assign d_req     = dREN | dWEN;
    assign fetch_due = iREN && (starve == STARVE_LIM);

    always_comb begin
        state_nx = state;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !fetch_due) begin
                    state_nx = DSERV;
                    grant_d  = 1'b1;
                end else if (iREN) begin
                    state_nx = ISERV;
                    grant_i  = 1'b1;
                end
            end
            DSERV, ISERV: begin
                if (ramready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // Grant stage: request captured here; the RAM sees only these registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            starve   <= '0;
            addr_p0  <= '0;
            store_p0 <= '0;
            ren_p0   <= 1'b0;
            wen_p0   <= 1'b0;
        end else if (grant_d) begin
            addr_p0  <= daddr;
            store_p0 <= dstore;
            wen_p0   <= dWEN;
            ren_p0   <= ~dWEN;
            if (iREN) starve <= starve_inc(starve);
        end else if (grant_i) begin
            addr_p0  <= iaddr;
            store_p0 <= '0;
            wen_p0   <= 1'b0;
            ren_p0   <= 1'b1;
            starve   <= '0;
        end else if (state != IDLE && ramready) begin
            ren_p0   <= 1'b0;
            wen_p0   <= 1'b0;
        end
    end

    assign ramREN   = ren_p0;
    assign ramWEN   = wen_p0;
    assign ramaddr  = addr_p0;
    assign ramstore = store_p0;

    // Hits are gated by the live request so a requester that gave up never sees a stale strobe
    assign dhit  = (state == DSERV) && ramready && d_req;
    assign ihit  = (state == ISERV) && ramready && iREN;
    assign dload = ramload;
    assign iload = ramload;

`ifdef MEMARB_PERF_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            istall_cnt <= '0;
            dstall_cnt <= '0;
        end else begin
            if (iREN && !ihit)  istall_cnt <= sat_inc32(istall_cnt);
            if (d_req && !dhit) dstall_cnt <= sat_inc32(dstall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus concurrent random requesters scored
// against a word-array memory model and the arbitration rules.
module tb_memory_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic              iREN, dREN, dWEN;
    logic [ADDR_W-1:0] iaddr, daddr;
    logic [DATA_W-1:0] dstore;
    logic              ihit, dhit;
    logic [DATA_W-1:0] iload, dload;
    logic              ramREN, ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore, ramload;
    logic              ramready;

    int n_checks = 0;
    int n_pass   = 0;

    int lat_cfg = 1;
    int wcnt    = 0;
    int cur_lat = 1;
    bit [31:0]   mem [256];
    bit [255:0]  written;
    logic [31:0] ref_mem [256];

    memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] seed(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0001_0011;
    endfunction

    assign ramload = written[ramaddr[9:2]] ? mem[ramaddr[9:2]] : seed(int'(ramaddr[9:2]));

    // RAM responder: ready in the lat-th cycle of a strobe; lat_cfg==0 picks 1..4 per access
    always @(negedge CLK) begin : ram_model
        int lat;
        if (RST || !(ramREN || ramWEN)) begin
            wcnt     <= 0;
            ramready <= 1'b0;
        end else begin
            lat = (wcnt != 0) ? cur_lat : ((lat_cfg != 0) ? lat_cfg : int'($urandom_range(4, 1)));
            cur_lat  <= lat;
            wcnt     <= wcnt + 1;
            ramready <= (wcnt + 1 >= lat);
            if ((wcnt + 1 >= lat) && ramWEN) begin
                mem[ramaddr[9:2]]     <= ramstore;
                written[ramaddr[9:2]] <= 1'b1;
            end
        end
    end

    task automatic cyc();
        @(negedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; RST = 1'b1;
        cyc(); cyc();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h44; daddr = 32'h88; dstore = 32'h1234;
        cyc(); cyc();
        n_checks++; if (ihit !== 1'b0)     $display("FAIL reset_ihit: got %0b want 0", ihit);       else n_pass++;
        n_checks++; if (dhit !== 1'b0)     $display("FAIL reset_dhit: got %0b want 0", dhit);       else n_pass++;
        n_checks++; if (ramREN !== 1'b0)   $display("FAIL reset_ramREN: got %0b want 0", ramREN);   else n_pass++;
        n_checks++; if (ramWEN !== 1'b0)   $display("FAIL reset_ramWEN: got %0b want 0", ramWEN);   else n_pass++;
        n_checks++; if (ramaddr !== '0)    $display("FAIL reset_ramaddr: got %h want 0", ramaddr);  else n_pass++;
        n_checks++; if (ramstore !== '0)   $display("FAIL reset_ramstore: got %h want 0", ramstore); else n_pass++;
        iREN = 1'b0; dREN = 1'b0; RST = 1'b0;
        cyc();
        n_checks++; if (ramREN !== 1'b0)   $display("FAIL reset_idle_after: got %0b want 0", ramREN); else n_pass++;
    endtask

    task automatic test_fetch_latency();
        int ren_cyc = 0, hits = 0, bad = 0;
        logic [31:0] got = '0;
        apply_reset();
        lat_cfg = 3; iaddr = 32'h40; iREN = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (ramREN && ramaddr == 32'h40) ren_cyc++;
            if (ramWEN) bad++;
            if (ihit) begin hits++; got = iload; #1; iREN = 1'b0; end
        end
        n_checks++; if (ren_cyc != 3)       $display("FAIL fetch_ren_cycles: got %0d want 3", ren_cyc);          else n_pass++;
        n_checks++; if (hits != 1)          $display("FAIL fetch_ihit_count: got %0d want 1", hits);             else n_pass++;
        n_checks++; if (got !== ref_mem[16]) $display("FAIL fetch_iload: got %h want %h", got, ref_mem[16]);     else n_pass++;
        n_checks++; if (bad != 0)           $display("FAIL fetch_no_write: got %0d write cycles want 0", bad);   else n_pass++;
    endtask

    task automatic test_write();
        int wen_cyc = 0, hits = 0, bad = 0, rhits = 0;
        logic [31:0] got = '0;
        apply_reset();
        lat_cfg = 2; daddr = 32'h100; dstore = 32'hDEADBEEF; dWEN = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (ramWEN) begin
                wen_cyc++;
                if (ramaddr !== 32'h100 || ramstore !== 32'hDEADBEEF || ramREN !== 1'b0) bad++;
            end
            if (dhit) begin hits++; ref_mem[64] = 32'hDEADBEEF; #1; dWEN = 1'b0; end
        end
        n_checks++; if (wen_cyc != 2) $display("FAIL write_wen_cycles: got %0d want 2", wen_cyc); else n_pass++;
        n_checks++; if (bad != 0)     $display("FAIL write_hold: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if (hits != 1)    $display("FAIL write_dhit_count: got %0d want 1", hits);    else n_pass++;
        dREN = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (dhit) begin rhits++; got = dload; #1; dREN = 1'b0; end
        end
        n_checks++; if (rhits != 1 || got !== 32'hDEADBEEF)
            $display("FAIL write_readback: got %h (hits %0d) want deadbeef (hits 1)", got, rhits); else n_pass++;
    endtask

    task automatic test_priority();
        int d_at = 0, i_at = 0, bubble_bad = 0;
        int exp_d = 2;
        int exp_i = 2 + 1 + 2;
        logic [31:0] dv = '0, iv = '0;
        apply_reset();
        lat_cfg = 2; iaddr = 32'h80; daddr = 32'h20; iREN = 1'b1; dREN = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (c == exp_d + 1 && (ramREN || ramWEN)) bubble_bad++;
            if (dhit) begin d_at = c; dv = dload; #1; dREN = 1'b0; end
            else if (ihit) begin i_at = c; iv = iload; #1; iREN = 1'b0; end
        end
        n_checks++; if (d_at != exp_d)      $display("FAIL prio_dhit_cycle: got %0d want %0d", d_at, exp_d); else n_pass++;
        n_checks++; if (i_at != exp_i)      $display("FAIL prio_ihit_cycle: got %0d want %0d", i_at, exp_i); else n_pass++;
        n_checks++; if (bubble_bad != 0)    $display("FAIL prio_bubble: got strobe in bubble want none");   else n_pass++;
        n_checks++; if (dv !== ref_mem[8])  $display("FAIL prio_dload: got %h want %h", dv, ref_mem[8]);    else n_pass++;
        n_checks++; if (iv !== ref_mem[32]) $display("FAIL prio_iload: got %h want %h", iv, ref_mem[32]);   else n_pass++;
    endtask

    task automatic test_starvation();
        byte exp_ev [10];
        byte ev [10];
        int  n = 0, since = 0;
        for (int e = 0; e < 10; e++) begin
            ev[e] = "-";
            if (since == STARVE_MAX) begin exp_ev[e] = "I"; since = 0; end
            else begin exp_ev[e] = "D"; since++; end
        end
        apply_reset();
        lat_cfg = 1; iaddr = 32'hC0; daddr = 32'h24; iREN = 1'b1; dREN = 1'b1;
        for (int c = 0; c < 60 && n < 10; c++) begin
            cyc();
            if (dhit) begin ev[n] = "D"; n++; end
            else if (ihit) begin ev[n] = "I"; n++; end
        end
        for (int e = 0; e < 10; e++) begin
            n_checks++; if (ev[e] != exp_ev[e])
                $display("FAIL starve_event_%0d: got %c want %c", e, ev[e], exp_ev[e]); else n_pass++;
        end
        iREN = 1'b0; dREN = 1'b0;
    endtask

    task automatic test_drop_mid();
        int ren_cyc = 0, hits = 0;
        bit ok = 1'b0;
        apply_reset();
        lat_cfg = 4; daddr = 32'h30; dREN = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (ramREN) ren_cyc++;
            if (dhit) hits++;
            if (c == 2) begin #1; dREN = 1'b0; end
        end
        n_checks++; if (ren_cyc != 4)   $display("FAIL drop_ren_cycles: got %0d want 4", ren_cyc); else n_pass++;
        n_checks++; if (hits != 0)      $display("FAIL drop_dhit: got %0d want 0", hits);          else n_pass++;
        n_checks++; if (ramREN !== 1'b0) $display("FAIL drop_idle: got ramREN %0b want 0", ramREN); else n_pass++;
        lat_cfg = 1; iaddr = 32'h40; iREN = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (ihit && !ok) begin ok = 1'b1; #1; iREN = 1'b0; end
        end
        iREN = 1'b0;
        n_checks++; if (!ok) $display("FAIL drop_followup_fetch: got no ihit want ihit"); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bad = 0, dseen = 0, d_before_i = -1, n = 0;
        apply_reset();
        lat_cfg = 4; iaddr = 32'h40; iREN = 1'b1;
        cyc(); cyc();
        n_checks++; if (ramREN !== 1'b1) $display("FAIL rstmid_pre_ramREN: got %0b want 1", ramREN); else n_pass++;
        #1; RST = 1'b1; #1;
        n_checks++; if (ramREN !== 1'b0) $display("FAIL rstmid_ramREN: got %0b want 0", ramREN);   else n_pass++;
        n_checks++; if (ihit !== 1'b0)   $display("FAIL rstmid_ihit: got %0b want 0", ihit);       else n_pass++;
        n_checks++; if (ramaddr !== '0)  $display("FAIL rstmid_ramaddr: got %h want 0", ramaddr);  else n_pass++;
        iREN = 1'b0;
        cyc(); RST = 1'b0;
        for (int c = 0; c < 4; c++) begin cyc(); if (ramREN || ihit) bad++; end
        n_checks++; if (bad != 0) $display("FAIL rstmid_idle: got %0d active cycles want 0", bad); else n_pass++;
        // Build up starvation credit, reset inside DSERV, then the full STARVE_MAX run must recur
        lat_cfg = 1; iaddr = 32'hC0; daddr = 32'h24; iREN = 1'b1; dREN = 1'b1;
        for (int c = 0; c < 20 && dseen < 2; c++) begin cyc(); if (dhit) dseen++; end
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0;
        cyc(); RST = 1'b0; iREN = 1'b1; dREN = 1'b1;
        for (int c = 0; c < 40 && d_before_i < 0; c++) begin
            cyc();
            if (dhit) n++;
            else if (ihit) d_before_i = n;
        end
        n_checks++; if (d_before_i != STARVE_MAX)
            $display("FAIL rstmid_starve_cleared: got %0d data hits before fetch want %0d", d_before_i, STARVE_MAX); else n_pass++;
        iREN = 1'b0; dREN = 1'b0;
    endtask

    task automatic i_thread();
        for (int n = 0; n < 25; n++) begin
            int idx, dseen;
            bit got;
            logic [31:0] val;
            repeat ($urandom_range(3, 0)) cyc();
            idx = int'($urandom_range(15, 0));
            iaddr = 32'(idx) << 2; iREN = 1'b1; got = 1'b0; dseen = 0; val = '0;
            for (int c = 0; c < 200 && !got; c++) begin
                cyc();
                if (dhit) dseen++;
                if (ihit) begin got = 1'b1; val = iload; end
            end
            n_checks++; if (!got) $display("FAIL rand_fetch_timeout: got no ihit want ihit (idx %0d)", idx); else n_pass++;
            n_checks++; if (got && val !== ref_mem[idx])
                $display("FAIL rand_iload: got %h want %h (idx %0d)", val, ref_mem[idx], idx); else n_pass++;
            n_checks++; if (dseen > STARVE_MAX + 1)
                $display("FAIL rand_starve_bound: got %0d data hits want <= %0d", dseen, STARVE_MAX + 1); else n_pass++;
            #1; iREN = 1'b0;
        end
    endtask

    task automatic d_thread();
        for (int n = 0; n < 35; n++) begin
            int idx, op;
            bit got, wr, ok;
            repeat ($urandom_range(3, 0)) cyc();
            idx = int'($urandom_range(15, 0));
            op  = int'($urandom_range(7, 0));
            wr  = (op >= 4);
            daddr = 32'(idx) << 2; dstore = $urandom;
            dREN = (op < 4) || (op == 7); dWEN = wr;
            got = 1'b0; ok = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                cyc();
                if (dhit) begin
                    got = 1'b1;
                    if (wr) begin ok = ramWEN && !ramREN; ref_mem[idx] = dstore; end
                    else ok = (dload === ref_mem[idx]);
                end
            end
            n_checks++; if (!got) $display("FAIL rand_data_timeout: got no dhit want dhit (op %0d)", op); else n_pass++;
            n_checks++; if (got && !ok)
                $display("FAIL rand_data_access: op %0d idx %0d dload %h want %h ramWEN %0b ramREN %0b",
                         op, idx, dload, ref_mem[idx], ramWEN, ramREN); else n_pass++;
            #1; dREN = 1'b0; dWEN = 1'b0;
        end
    endtask

    task automatic test_random();
        apply_reset();
        lat_cfg = 0;
        fork
            i_thread();
            d_thread();
        join
        lat_cfg = 1;
    endtask

    initial begin
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
        test_reset();
        test_fetch_latency();
        test_write();
        test_priority();
        test_starvation();
        test_drop_mid();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want completion within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
